// File: rtl/led_multi_blink.sv
// N-channel LED/IO pattern generator: shared 1 ms prescaler, per-channel OFF/ON/BLINK/BURST
// modes configured over a valid/ready port, and a Sync strobe that phase-aligns running channels.
module led_multi_blink #(
   parameter int unsigned CLOCK_FREQUENCY  = 27_000_000,
   parameter int unsigned NUM_CHANNELS     = 2,
   parameter int unsigned PERIOD_W         = 12,
   parameter int unsigned BURST_PULSES     = 3,
   parameter int unsigned BURST_GAP_HALVES = 4,
   parameter logic [1:0]  RESET_MODE       = 2'd2,
   parameter int unsigned RESET_PERIOD_MS  = 500
) (
   input  logic                    Clock,
   input  logic                    Reset_n,
   input  logic                    Cfg_valid,
   output logic                    Cfg_ready,
   input  logic [3:0]              Cfg_channel,
   input  logic [1:0]              Cfg_mode,
   input  logic [PERIOD_W-1:0]     Cfg_period_ms,
   output logic                    Cfg_error,
   input  logic                    Sync,
   output logic                    Tick_1ms,
   output logic [NUM_CHANNELS-1:0] IO_voltage
);

   localparam int unsigned DIV         = CLOCK_FREQUENCY / 1000;
   localparam int unsigned PRE_W       = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned HALVES      = 2 * BURST_PULSES + BURST_GAP_HALVES;
   localparam int unsigned HALF_W      = $clog2(HALVES + 1);
   localparam int unsigned RST_PERIOD  = (RESET_PERIOD_MS == 0) ? 1 : RESET_PERIOD_MS;

   localparam logic [1:0] MODE_OFF   = 2'd0;
   localparam logic [1:0] MODE_BLINK = 2'd2;
   localparam logic [1:0] MODE_BURST = 2'd3;

   logic [PRE_W-1:0] pre_cnt_reg;
   logic             tick_reg;

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         pre_cnt_reg <= '0;
         tick_reg    <= 1'b0;
      end else begin
         tick_reg    <= (pre_cnt_reg == PRE_W'(DIV - 1));
         pre_cnt_reg <= (pre_cnt_reg == PRE_W'(DIV - 1)) ? '0 : pre_cnt_reg + 1'b1;
      end
   end

   assign Tick_1ms = tick_reg;

   // Config handshake: accept in IDLE, apply the captured write in COMMIT.
   typedef enum logic {ST_IDLE, ST_COMMIT} cfg_state_t;

   cfg_state_t            state_reg, state_next;
   logic                  accept;
   logic                  commit;
   logic [3:0]            wr_ch_reg;
   logic [1:0]            wr_mode_reg;
   logic [PERIOD_W-1:0]   wr_period_reg;
   logic                  err_reg;

   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (Cfg_valid) begin
               accept     = 1'b1;
               state_next = ST_COMMIT;
            end
         end
         ST_COMMIT: state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   assign commit    = (state_reg == ST_COMMIT);
   assign Cfg_ready = (state_reg == ST_IDLE);
   assign Cfg_error = err_reg;

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_reg     <= ST_IDLE;
         wr_ch_reg     <= '0;
         wr_mode_reg   <= '0;
         wr_period_reg <= '0;
         err_reg       <= 1'b0;
      end else begin
         state_reg <= state_next;
         err_reg   <= commit && ({1'b0, wr_ch_reg} >= 5'(NUM_CHANNELS));
         if (accept) begin
            wr_ch_reg     <= Cfg_channel;
            wr_mode_reg   <= Cfg_mode;
            wr_period_reg <= (Cfg_period_ms == '0) ? PERIOD_W'(1) : Cfg_period_ms;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
         logic [1:0]          mode_reg;
         logic [PERIOD_W-1:0] period_reg;
         logic [PERIOD_W-1:0] ms_cnt_reg;
         logic [HALF_W-1:0]   half_cnt_reg;
         logic                io_reg;
         logic                wr_hit;
         logic                running;
         logic                half_end;
         logic [HALF_W-1:0]   half_inc;
         logic                burst_level;

         assign wr_hit   = commit && (wr_ch_reg == 4'(gi));
         assign running  = (mode_reg == MODE_BLINK) || (mode_reg == MODE_BURST);
         assign half_end = (ms_cnt_reg == period_reg - 1'b1);
         assign half_inc = (half_cnt_reg == HALF_W'(HALVES - 1)) ? '0 : half_cnt_reg + 1'b1;
         // Even half-periods inside the pulse train are high; the trailing gap is low.
         assign burst_level = (half_inc < HALF_W'(2 * BURST_PULSES)) && !half_inc[0];

         always_ff @(posedge Clock or negedge Reset_n) begin
            if (!Reset_n) begin
               mode_reg     <= RESET_MODE;
               period_reg   <= PERIOD_W'(RST_PERIOD);
               ms_cnt_reg   <= '0;
               half_cnt_reg <= '0;
               io_reg       <= 1'b0;
            end else if (wr_hit) begin
               mode_reg     <= wr_mode_reg;
               period_reg   <= wr_period_reg;
               ms_cnt_reg   <= '0;
               half_cnt_reg <= '0;
               io_reg       <= (wr_mode_reg != MODE_OFF);
            end else if (running) begin
               if (Sync) begin
                  ms_cnt_reg   <= '0;
                  half_cnt_reg <= '0;
                  io_reg       <= 1'b1;
               end else if (tick_reg) begin
                  if (half_end) begin
                     ms_cnt_reg <= '0;
                     if (mode_reg == MODE_BLINK) begin
                        io_reg <= ~io_reg;
                     end else begin
                        half_cnt_reg <= half_inc;
                        io_reg       <= burst_level;
                     end
                  end else begin
                     ms_cnt_reg <= ms_cnt_reg + 1'b1;
                  end
               end
            end
         end

         assign IO_voltage[gi] = io_reg;
      end
   endgenerate

endmodule

// File: tb/tb_led_multi_blink.sv
// Bench for led_multi_blink: a tick-count based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized writes and Sync strobes.
module tb_led_multi_blink;

   localparam int NCH    = 2;
   localparam int PW     = 12;
   localparam int BP     = 3;
   localparam int GAP    = 4;
   localparam int HALVES = 2 * BP + GAP;
   localparam int DIV    = 10;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           cfg_valid = 1'b0;
   logic           cfg_ready;
   logic [3:0]     cfg_channel = '0;
   logic [1:0]     cfg_mode = '0;
   logic [PW-1:0]  cfg_period = '0;
   logic           cfg_error;
   logic           sync = 1'b0;
   logic           tick;
   logic [NCH-1:0] io;

   always #5 clk = ~clk;

   led_multi_blink #(
      .CLOCK_FREQUENCY(10_000),
      .NUM_CHANNELS   (NCH)
   ) dut (
      .Clock        (clk),
      .Reset_n      (rst_n),
      .Cfg_valid    (cfg_valid),
      .Cfg_ready    (cfg_ready),
      .Cfg_channel  (cfg_channel),
      .Cfg_mode     (cfg_mode),
      .Cfg_period_ms(cfg_period),
      .Cfg_error    (cfg_error),
      .Sync         (sync),
      .Tick_1ms     (tick),
      .IO_voltage   (io)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: each channel is described by its mode, half-period and the number of ticks
   // seen since its last restart; outputs follow from plain division of that count.
   int m_cyc;
   bit m_tick, m_ready, m_err, m_pend;
   int m_pch, m_pmode, m_pper;
   int m_mode[NCH];
   int m_per[NCH];
   int m_t[NCH];
   bit m_from_rst[NCH];
   bit m_tick_now;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cyc = 0; m_tick = 0; m_ready = 1; m_err = 0; m_pend = 0;
         for (int c = 0; c < NCH; c++) begin
            m_mode[c] = 2; m_per[c] = 500; m_t[c] = 0; m_from_rst[c] = 1;
         end
      end else begin
         m_tick_now = m_tick;
         m_cyc++;
         m_tick = (m_cyc % DIV == 0);
         m_err = 0;
         for (int c = 0; c < NCH; c++) begin
            if (m_pend && m_pch == c) begin
               m_mode[c] = m_pmode;
               m_per[c] = (m_pper == 0) ? 1 : m_pper;
               m_t[c] = 0;
               m_from_rst[c] = 0;
            end else if (m_mode[c] >= 2) begin
               if (sync) begin
                  m_t[c] = 0;
                  m_from_rst[c] = 0;
               end else if (m_tick_now) begin
                  m_t[c]++;
               end
            end
         end
         if (m_pend) begin
            m_err = (m_pch >= NCH);
            m_pend = 0;
            m_ready = 1;
         end else if (cfg_valid && m_ready) begin
            m_pch = int'(cfg_channel); m_pmode = int'(cfg_mode); m_pper = int'(cfg_period);
            m_pend = 1;
            m_ready = 0;
         end
      end
   end

   function automatic logic exp_io(input int c);
      int ph;
      int h;
      ph = m_t[c] / m_per[c];
      h = ph % HALVES;
      case (m_mode[c])
         0: return 1'b0;
         1: return !m_from_rst[c];
         2: return m_from_rst[c] ? (ph % 2 == 1) : (ph % 2 == 0);
         default: begin
            if (m_from_rst[c] && m_t[c] < m_per[c]) return 1'b0;
            return (h < 2 * BP) && (h % 2 == 0);
         end
      endcase
   endfunction

   logic [NCH-1:0] e_io;

   always @(negedge clk) begin
      for (int c = 0; c < NCH; c++) e_io[c] = exp_io(c);
      check("tick", tick, m_tick);
      check("ready", cfg_ready, m_ready);
      check("error", cfg_error, m_err);
      check("io", io, e_io);
   end

   task automatic cfg_write(input int ch, input int mode, input int per, input bit now);
      int i;
      i = 0;
      if (!now) @(negedge clk);
      cfg_valid = 1'b1;
      cfg_channel = 4'(ch);
      cfg_mode = 2'(mode);
      cfg_period = PW'(per);
      while (!cfg_ready && i < 10) begin
         @(negedge clk);
         i++;
      end
      check("accept_timeout", cfg_ready, 1);
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   task automatic sync_pulse(input bit now);
      if (!now) @(negedge clk);
      sync = 1'b1;
      @(negedge clk);
      sync = 1'b0;
   endtask

   // Returns at the negedge just after the next tick has been consumed by the channels.
   task automatic wait_tick_done();
      int i;
      i = 0;
      while (!tick && i < 20) begin
         @(negedge clk);
         i++;
      end
      check("tick_timeout", tick, 1);
      @(negedge clk);
   endtask

   task automatic first_tick(output int n);
      n = 0;
      do begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end while (!tick && n < 40);
   endtask

   initial begin
      int n;
      logic [19:0] pat;

      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;

      // Defaults: tick every 10 clocks, channel 0 blinks at 500 ms
      first_tick(n);
      check("first_tick_edge", n, 10);
      while (!io[0] && n < 6000) begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      check("io0_first_rise_edge", n, 5001);

      // Channel 1 BLINK period 3
      cfg_write(1, 2, 3, 0);
      check("t2_ready_low", cfg_ready, 0);
      @(negedge clk);
      check("t2_io1_high", io[1], 1);
      repeat (3) wait_tick_done();
      check("t2_io1_after3", io[1], 0);

      // Channel 0 BURST period 2: tick-indexed expected level
      pat = 20'b0000000000_1100110011;
      cfg_write(0, 3, 2, 0);
      @(negedge clk);
      check("t3_burst_k0", io[0], pat[0]);
      for (int k = 1; k <= 20; k++) begin
         wait_tick_done();
         check($sformatf("t3_burst_k%0d", k), io[0], pat[k % 20]);
      end

      // Sync with ch0 in a low half and ch1 ON
      cfg_write(1, 1, 7, 0);
      @(negedge clk);
      repeat (2) wait_tick_done();
      check("t5_pre_sync_low", io[0], 0);
      sync_pulse(0);
      check("t5_sync_io", io, 2'b11);
      repeat (2) wait_tick_done();
      check("t5_after_sync", io, 2'b10);

      // Period 0 behaves as 1; bad channel index flags an error
      cfg_write(0, 2, 0, 0);
      @(negedge clk);
      check("t4_p0_k0", io[0], 1);
      wait_tick_done();
      check("t4_p0_k1", io[0], 0);
      wait_tick_done();
      check("t4_p0_k2", io[0], 1);
      cfg_write(5, 1, 9, 0);
      @(negedge clk);
      check("t4_err_pulse", cfg_error, 1);
      check("t4_ch1_kept", io[1], 1);
      @(negedge clk);
      check("t4_err_clear", cfg_error, 0);

      // Async reset mid-burst while a write is pending
      cfg_write(0, 3, 2, 0);
      @(negedge clk);
      repeat (3) wait_tick_done();
      cfg_write(1, 0, 5, 0);
      #2 rst_n = 1'b0;
      #1;
      check("t6_io_async", io, 2'b00);
      check("t6_ready_async", cfg_ready, 1);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      first_tick(n);
      check("t6_first_tick_edge", n, 10);
      check("t6_io_after_release", io, 2'b00);

      // Randomized writes (including bad indices, held valid) and Sync strobes
      for (int it = 0; it < 150; it++) begin
         repeat ($urandom_range(0, 12)) @(negedge clk);
         case ($urandom_range(0, 3))
            0, 1: cfg_write($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4),
                            $urandom_range(0, 1));
            2: sync_pulse(0);
            default: begin
               cfg_write($urandom_range(0, 1), $urandom_range(2, 3), $urandom_range(1, 3), 0);
               sync_pulse(1);
            end
         endcase
      end
      repeat (30) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
